packet_source: RTL and testbench
================================

PACKET_SOURCE -- requirements
Module: packet_source

Interface
REQ-001 Parameter TDATAW, default 32: AXI-Stream data width.
REQ-002 Parameter TDESTW, default 4: TDEST width.
REQ-003 Parameter TIDW, default 2: TID width.
REQ-004 Parameter LENW, default 8: beats-per-packet field width.
REQ-005 Parameter NPKTW, default 8: packet-count field width.
REQ-006 Parameter GAPW, default 4: inter-packet gap field width.
REQ-007 CLK  input  1  clock; all logic on rising edge.
REQ-008 RST_N  input  1  reset, asynchronous, active-low.
REQ-009 START  input  1  single-cycle pulse; begins a run.
REQ-010 CFG_LEN  input  LENW  beats per packet.
REQ-011 CFG_NPKT  input  NPKTW  packets per run.
REQ-012 CFG_GAP  input  GAPW  idle cycles between packets.
REQ-013 CFG_SEED  input  TDATAW  first data word of run.
REQ-014 CFG_DEST  input  TDESTW  TDEST for all beats.
REQ-015 CFG_ID  input  TIDW  TID for all beats.
REQ-016 BUSY  output  1  high while run in progress.
REQ-017 DONE  output  1  high after run completes.
REQ-018 AXIS_M_TVALID/TREADY/TDATA/TLAST/TID/TDEST  output/input/output/output/output/output  1/1/TDATAW/1/TIDW/TDESTW  AXI-Stream master into the NoC.

Function
REQ-019 FSM states IDLE, SEND, GAP, FINISH; all outputs registered.
REQ-020 IDLE: START=1 samples all CFG_* into internal registers, clears DONE, sets BUSY; next state SEND, or FINISH if CFG_NPKT=0.
REQ-021 Latency: START at edge n -> TVALID=1 in cycle n+1.
REQ-022 CFG_LEN=0 is treated as 1 beat.
REQ-023 Handshake = TVALID & TREADY at a rising edge; TVALID, once high, stays high with TDATA/TLAST/TID/TDEST stable until handshake.
REQ-024 TDATA starts at CFG_SEED, increments by 1 per handshake across packet boundaries, wraps modulo 2^TDATAW.
REQ-025 TLAST=1 exactly on beat index CFG_LEN-1 of each packet; beat counter resets to 0 after TLAST handshake.
REQ-026 After TLAST handshake: if packets remaining and CFG_GAP>0 -> GAP, TVALID=0 for exactly CFG_GAP cycles, then SEND; if CFG_GAP=0 -> next packet's first beat valid in the very next cycle (no bubble).
REQ-027 After TLAST handshake of final packet -> FINISH: TVALID=0, BUSY=0, DONE=1 next cycle; then IDLE with DONE held high until next START.
REQ-028 START while BUSY=1 is ignored; CFG_* changes during run have no effect.
REQ-029 TREADY low indefinitely stalls without loss or duplication; TREADY ignored when TVALID=0.
REQ-030 Packet counter width NPKTW, beat counter LENW, gap counter GAPW; no overflow possible for legal inputs.

Reset
REQ-031 RST_N=0 asynchronously forces state IDLE, TVALID=0, TLAST=0, TDATA=0, TID=0, TDEST=0, BUSY=0, DONE=0, all counters 0.
REQ-032 Reset mid-packet aborts run; no partial-packet completion after release; next START begins fresh run.
REQ-033 First START accepted in first cycle after RST_N deasserts.

Structure
REQ-034 FSM state enum and default widths live in shared package noc_pkg, reused by sink-side blocks.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 LEN=4, NPKT=1, SEED=0x10, DEST=3, ID=1, TREADY=1 -> TDATA 0x10..0x13, TLAST on 0x13, DONE=1 one cycle after last handshake.
REQ-037 LEN=2, NPKT=3, GAP=0, TREADY=1 -> 6 consecutive valid cycles, TLAST on beats 2,4,6, no bubble.
REQ-038 LEN=3, NPKT=2, GAP=5 -> exactly 5 TVALID=0 cycles between packets; TDATA continuous across gap.
REQ-039 TREADY toggled pseudo-randomly 50% -> payload stable while stalled, no duplicate/missing words, final word SEED+LEN*NPKT-1.
REQ-040 NPKT=0 -> no TVALID, DONE=1 two cycles after START; SEED=0xFFFFFFFF, LEN=2 -> TDATA 0xFFFFFFFF then 0x00000000.
REQ-041 RST_N asserted mid-packet -> outputs zero immediately; new START after release restarts from new SEED with beat 0.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC stream definitions used by the packet source and the sink-side
// blocks. It holds the default field widths and the sequencer state encoding.
// No ports. This is a package.
// -----------------------------------------------------------------------------
package noc_pkg;

  // Default field widths for stream endpoints
  localparam int DEF_TDATAW = 32;
  localparam int DEF_TDESTW = 4;
  localparam int DEF_TIDW   = 2;
  localparam int DEF_LENW   = 8;
  localparam int DEF_NPKTW  = 8;
  localparam int DEF_GAPW   = 4;

  // Packet sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } stream_state_e;

endpackage

// File: rtl/packet_source.sv
// -----------------------------------------------------------------------------
// packet_source
// AXI-Stream packet generator that drives traffic into the NoC. A START pulse
// captures the run configuration. The block then emits CFG_NPKT packets of
// CFG_LEN beats each, with CFG_GAP idle cycles between packets. The data is an
// incrementing word sequence that begins at CFG_SEED.
//
// Ports
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   START           single-cycle pulse that begins a run; ignored while busy
//   CFG_LEN         beats per packet (a value of 0 gives 1 beat)
//   CFG_NPKT        packets per run (a value of 0 gives an empty run)
//   CFG_GAP         idle cycles between packets
//   CFG_SEED        first data word of the run
//   CFG_DEST/CFG_ID TDEST/TID used for every beat
//   BUSY, DONE      run status; DONE stays high until the next START
//   AXIS_M_*        AXI-Stream master interface; every output is registered
// -----------------------------------------------------------------------------
module packet_source
  import noc_pkg::*;
#(
  parameter int TDATAW = DEF_TDATAW,
  parameter int TDESTW = DEF_TDESTW,
  parameter int TIDW   = DEF_TIDW,
  parameter int LENW   = DEF_LENW,
  parameter int NPKTW  = DEF_NPKTW,
  parameter int GAPW   = DEF_GAPW
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [LENW-1:0]   CFG_LEN,
  input  logic [NPKTW-1:0]  CFG_NPKT,
  input  logic [GAPW-1:0]   CFG_GAP,
  input  logic [TDATAW-1:0] CFG_SEED,
  input  logic [TDESTW-1:0] CFG_DEST,
  input  logic [TIDW-1:0]   CFG_ID,
  output logic              BUSY,
  output logic              DONE,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  stream_state_e     state_r,    state_s;
  logic [LENW-1:0]   last_idx_r, last_idx_s;  // beat index that carries TLAST
  logic [LENW-1:0]   beat_r,     beat_s;
  logic [NPKTW-1:0]  pkt_r,      pkt_s;       // packets still to send
  logic [GAPW-1:0]   gap_cfg_r,  gap_cfg_s;
  logic [GAPW-1:0]   gap_cnt_r,  gap_cnt_s;
  logic [TDATAW-1:0] data_r,     data_s;
  logic              tvalid_r,   tvalid_s;
  logic              tlast_r,    tlast_s;
  logic [TIDW-1:0]   tid_r,      tid_s;
  logic [TDESTW-1:0] tdest_r,    tdest_s;
  logic              busy_r,     busy_s;
  logic              done_r,     done_s;
  logic              hs_s;

  assign hs_s = tvalid_r & AXIS_M_TREADY;

  // Next-state and next-output logic for the packet sequencer
  always_comb begin
    state_s    = state_r;
    last_idx_s = last_idx_r;
    beat_s     = beat_r;
    pkt_s      = pkt_r;
    gap_cfg_s  = gap_cfg_r;
    gap_cnt_s  = gap_cnt_r;
    data_s     = data_r;
    tvalid_s   = tvalid_r;
    tlast_s    = tlast_r;
    tid_s      = tid_r;
    tdest_s    = tdest_r;
    busy_s     = busy_r;
    done_s     = done_r;

    case (state_r)
      ST_IDLE: begin
        if (START) begin
          // Store the index of the last beat so that a length of 0 needs no
          // special case later.
          last_idx_s = (CFG_LEN == {LENW{1'b0}}) ? {LENW{1'b0}} : (CFG_LEN - LENW'(1));
          beat_s     = {LENW{1'b0}};
          pkt_s      = CFG_NPKT;
          gap_cfg_s  = CFG_GAP;
          gap_cnt_s  = {GAPW{1'b0}};
          data_s     = CFG_SEED;
          tid_s      = CFG_ID;
          tdest_s    = CFG_DEST;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          if (CFG_NPKT == {NPKTW{1'b0}}) begin
            state_s  = ST_FINISH;
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
          end else begin
            state_s  = ST_SEND;
            tvalid_s = 1'b1;
            tlast_s  = (CFG_LEN <= LENW'(1));
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (hs_s) begin
          data_s = data_r + TDATAW'(1);
          if (tlast_r) begin
            beat_s  = {LENW{1'b0}};
            pkt_s   = pkt_r - NPKTW'(1);
            tlast_s = (last_idx_r == {LENW{1'b0}});
            if (pkt_r == NPKTW'(1)) begin
              state_s  = ST_FINISH;
              tvalid_s = 1'b0;
              tlast_s  = 1'b0;
            end else if (gap_cfg_r != {GAPW{1'b0}}) begin
              state_s   = ST_GAP;
              tvalid_s  = 1'b0;
              gap_cnt_s = gap_cfg_r;
            end else begin
              // When there is no gap, the next packet's first beat follows at once.
              state_s  = ST_SEND;
              tvalid_s = 1'b1;
            end
          end else begin
            beat_s  = beat_r + LENW'(1);
            tlast_s = ((beat_r + LENW'(1)) == last_idx_r);
          end
        end else begin
          // Stalled: hold the beat unchanged.
          state_s = ST_SEND;
        end
      end

      ST_GAP: begin
        // TVALID rises on the edge that ends the last idle cycle.
        if (gap_cnt_r == GAPW'(1)) begin
          state_s   = ST_SEND;
          tvalid_s  = 1'b1;
          gap_cnt_s = {GAPW{1'b0}};
        end else begin
          gap_cnt_s = gap_cnt_r - GAPW'(1);
        end
      end

      ST_FINISH: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end

      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with asynchronous reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      last_idx_r <= {LENW{1'b0}};
      beat_r     <= {LENW{1'b0}};
      pkt_r      <= {NPKTW{1'b0}};
      gap_cfg_r  <= {GAPW{1'b0}};
      gap_cnt_r  <= {GAPW{1'b0}};
      data_r     <= {TDATAW{1'b0}};
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      tid_r      <= {TIDW{1'b0}};
      tdest_r    <= {TDESTW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_idx_r <= last_idx_s;
      beat_r     <= beat_s;
      pkt_r      <= pkt_s;
      gap_cfg_r  <= gap_cfg_s;
      gap_cnt_r  <= gap_cnt_s;
      data_r     <= data_s;
      tvalid_r   <= tvalid_s;
      tlast_r    <= tlast_s;
      tid_r      <= tid_s;
      tdest_r    <= tdest_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign BUSY          = busy_r;
  assign DONE          = done_r;
  assign AXIS_M_TVALID = tvalid_r;
  assign AXIS_M_TDATA  = data_r;
  assign AXIS_M_TLAST  = tlast_r;
  assign AXIS_M_TID    = tid_r;
  assign AXIS_M_TDEST  = tdest_r;

endmodule

// File: tb/tb_packet_source.sv
// -----------------------------------------------------------------------------
// tb_packet_source
// Self-checking bench for packet_source. For each run, the expected beat stream
// is built from the run parameters: beat k carries SEED+k, and TLAST is set when
// k mod LEN is LEN-1. Each observed handshake is compared against that stream.
// The bench also checks the idle gaps, the stall stability and the BUSY/DONE
// timing.
// -----------------------------------------------------------------------------
module tb_packet_source;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [7:0]  CFG_LEN;
  logic [7:0]  CFG_NPKT;
  logic [3:0]  CFG_GAP;
  logic [31:0] CFG_SEED;
  logic [3:0]  CFG_DEST;
  logic [1:0]  CFG_ID;
  logic        BUSY;
  logic        DONE;
  logic        AXIS_M_TVALID;
  logic        AXIS_M_TREADY;
  logic [31:0] AXIS_M_TDATA;
  logic        AXIS_M_TLAST;
  logic [1:0]  AXIS_M_TID;
  logic [3:0]  AXIS_M_TDEST;

  int checks = 0;
  int errors = 0;

  packet_source dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .START         (START),
    .CFG_LEN       (CFG_LEN),
    .CFG_NPKT      (CFG_NPKT),
    .CFG_GAP       (CFG_GAP),
    .CFG_SEED      (CFG_SEED),
    .CFG_DEST      (CFG_DEST),
    .CFG_ID        (CFG_ID),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .AXIS_M_TVALID (AXIS_M_TVALID),
    .AXIS_M_TREADY (AXIS_M_TREADY),
    .AXIS_M_TDATA  (AXIS_M_TDATA),
    .AXIS_M_TLAST  (AXIS_M_TLAST),
    .AXIS_M_TID    (AXIS_M_TID),
    .AXIS_M_TDEST  (AXIS_M_TDEST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", name, tag, obs, exp);
    end
  endtask

  // One complete run: start it, then follow every beat against the reference stream.
  task automatic run_case(input string name, input int len, input int npkt, input int gap,
                          input logic [31:0] seed, input logic [3:0] dest, input logic [1:0] id,
                          input int ready_pct);
    int          leff, total, idx, cyc, idle_run, exp_idle;
    bit          gap_pending, prev_stall, prev_last;
    logic [31:0] prev_data, exp_data;
    leff  = (len == 0) ? 1 : len;
    total = leff * npkt;
    @(negedge CLK);
    CFG_LEN  = 8'(len);
    CFG_NPKT = 8'(npkt);
    CFG_GAP  = 4'(gap);
    CFG_SEED = seed;
    CFG_DEST = dest;
    CFG_ID   = id;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
    // Changes to the configuration during a run must have no effect.
    CFG_LEN  = 8'($urandom);
    CFG_NPKT = 8'($urandom);
    CFG_GAP  = 4'($urandom);
    CFG_SEED = $urandom;
    CFG_DEST = 4'($urandom);
    CFG_ID   = 2'($urandom);
    check(name, "start_valid", 64'(AXIS_M_TVALID), 64'(npkt != 0));
    check(name, "start_busy", 64'(BUSY), 64'd1);
    check(name, "start_done", 64'(DONE), 64'd0);

    idx = 0; cyc = 0; idle_run = 0; exp_idle = 0;
    gap_pending = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = 32'd0;
    while (idx < total && cyc < 3000) begin
      AXIS_M_TREADY = ($urandom_range(99) < ready_pct);
      START = ($urandom_range(7) == 0);   // a START pulse while busy must be ignored
      if (prev_stall) begin
        check(name, "hold_valid", 64'(AXIS_M_TVALID), 64'd1);
        check(name, "hold_data", 64'(AXIS_M_TDATA), 64'(prev_data));
        check(name, "hold_last", 64'(AXIS_M_TLAST), 64'(prev_last));
      end
      if (gap_pending) begin
        if (AXIS_M_TVALID) begin
          check(name, "idle_cycles", 64'(idle_run), 64'(exp_idle));
          gap_pending = 1'b0;
        end else begin
          idle_run++;
        end
      end
      if (AXIS_M_TVALID && AXIS_M_TREADY) begin
        exp_data = seed + 32'(idx);
        check(name, "data", 64'(AXIS_M_TDATA), 64'(exp_data));
        check(name, "last", 64'(AXIS_M_TLAST), 64'((idx % leff) == (leff - 1)));
        check(name, "tid", 64'(AXIS_M_TID), 64'(id));
        check(name, "tdest", 64'(AXIS_M_TDEST), 64'(dest));
        idx++;
        gap_pending = (idx < total);
        idle_run    = 0;
        exp_idle    = ((idx % leff) == 0) ? gap : 0;
      end
      prev_stall = AXIS_M_TVALID && !AXIS_M_TREADY;
      prev_data  = AXIS_M_TDATA;
      prev_last  = AXIS_M_TLAST;
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    check(name, "beats_seen", 64'(idx), 64'(total));
    // FINISH cycle: the stream is idle and DONE has not risen yet.
    check(name, "fin_valid", 64'(AXIS_M_TVALID), 64'd0);
    check(name, "fin_busy", 64'(BUSY), 64'd1);
    check(name, "fin_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    check(name, "done", 64'(DONE), 64'd1);
    check(name, "done_busy", 64'(BUSY), 64'd0);
    check(name, "done_valid", 64'(AXIS_M_TVALID), 64'd0);
    @(negedge CLK);
    check(name, "done_held", 64'(DONE), 64'd1);
  endtask

  initial begin
    RST_N = 1'b1; START = 1'b0; AXIS_M_TREADY = 1'b0;
    CFG_LEN = 8'd0; CFG_NPKT = 8'd0; CFG_GAP = 4'd0;
    CFG_SEED = 32'd0; CFG_DEST = 4'd0; CFG_ID = 2'd0;
    #1 RST_N = 1'b0;
    #2;
    check("reset", "valid", 64'(AXIS_M_TVALID), 64'd0);
    check("reset", "data", 64'(AXIS_M_TDATA), 64'd0);
    check("reset", "busy", 64'(BUSY), 64'd0);
    check("reset", "done", 64'(DONE), 64'd0);
    // Release between edges, so that run_case's START lands on the first edge after release.
    #4 RST_N = 1'b1;

    run_case("single", 4, 1, 0, 32'h0000_0010, 4'd3, 2'd1, 100);
    run_case("no_gap", 2, 3, 0, $urandom, 4'd5, 2'd2, 100);
    run_case("gap5", 3, 2, 5, $urandom, 4'd9, 2'd0, 100);
    run_case("stall", 5, 4, 2, $urandom, 4'd7, 2'd3, 50);
    run_case("npkt0", 4, 0, 3, $urandom, 4'd1, 2'd1, 100);
    run_case("wrap", 2, 1, 0, 32'hFFFF_FFFF, 4'd2, 2'd2, 100);
    run_case("len0", 0, 3, 1, $urandom, 4'd4, 2'd0, 70);

    for (int r = 0; r < 6; r++) begin
      run_case("rand", int'($urandom_range(6)), int'($urandom_range(4)), int'($urandom_range(3)),
               $urandom, 4'($urandom), 2'($urandom), int'($urandom_range(100, 30)));
    end

    // Reset in the middle of a packet aborts the run.
    @(negedge CLK);
    CFG_LEN = 8'd6; CFG_NPKT = 8'd2; CFG_GAP = 4'd0;
    CFG_SEED = 32'hA5A5_0000; CFG_DEST = 4'd15; CFG_ID = 2'd3;
    AXIS_M_TREADY = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("midrst", "pre_valid", 64'(AXIS_M_TVALID), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check("midrst", "valid", 64'(AXIS_M_TVALID), 64'd0);
    check("midrst", "data", 64'(AXIS_M_TDATA), 64'd0);
    check("midrst", "last", 64'(AXIS_M_TLAST), 64'd0);
    check("midrst", "tid", 64'(AXIS_M_TID), 64'd0);
    check("midrst", "tdest", 64'(AXIS_M_TDEST), 64'd0);
    check("midrst", "busy", 64'(BUSY), 64'd0);
    check("midrst", "done", 64'(DONE), 64'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("midrst", "no_resume", 64'(AXIS_M_TVALID), 64'd0);
    end
    run_case("after_rst", 3, 2, 1, 32'h1234_5678, 4'd6, 2'd1, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
